// File: rtl/variable_delay_line.sv
// Run-time adjustable sample delay line for the audio path.
// Circular buffer of MAX_LEN samples; advances one step per enable strobe.
module variable_delay_line #(
  parameter int WIDTH   = 12,
  parameter int MAX_LEN = 16,
  parameter int DW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             clear,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             primed
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = DW + 1;
  localparam logic [DW-1:0] MAX_D   = DW'(MAX_LEN);
  localparam logic [AW-1:0] LAST_WP = AW'(MAX_LEN - 1);

  // Sample storage: no reset so it maps onto RAM.
  logic [WIDTH-1:0] mem [MAX_LEN];

  logic [AW-1:0]    wp_q, wp_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             primed_q, primed_d;

  logic [DW-1:0]    d_eff;
  logic [CW-1:0]    wp_ext;
  logic [CW-1:0]    d_ext;
  logic [AW-1:0]    rd_idx;
  logic             wr_en;
  logic             hit;

  // Out-of-range delays clamp to the buffer depth.
  always_comb begin
    d_eff = (delay > MAX_D) ? MAX_D : delay;
  end

  // Wrap by conditional add rather than masking so any MAX_LEN works.
  // At d_eff == MAX_LEN the read lands on wp itself: the oldest sample.
  always_comb begin
    wp_ext = CW'(wp_q);
    d_ext  = CW'(d_eff);
    if (wp_ext >= d_ext) begin
      rd_idx = AW'(wp_ext - d_ext);
    end else begin
      rd_idx = AW'(wp_ext + CW'(MAX_LEN) - d_ext);
    end
    hit = (fill_q >= d_eff);
  end

  always_comb begin
    wp_d     = wp_q;
    fill_d   = fill_q;
    out_d    = out_q;
    primed_d = primed_q;
    wr_en    = 1'b0;
    if (clear) begin
      wp_d     = '0;
      fill_d   = '0;
      out_d    = '0;
      primed_d = 1'b0;
    end else if (enable) begin
      wr_en  = 1'b1;
      wp_d   = (wp_q == LAST_WP) ? '0 : wp_q + 1'b1;
      fill_d = (fill_q == MAX_D) ? fill_q : fill_q + 1'b1;
      if (d_eff == '0) begin
        out_d    = in;
        primed_d = 1'b1;
      end else if (hit) begin
        out_d    = mem[rd_idx];
        primed_d = 1'b1;
      end else begin
        out_d    = '0;
        primed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q     <= '0;
      fill_q   <= '0;
      out_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      fill_q   <= fill_d;
      out_q    <= out_d;
      primed_q <= primed_d;
    end
  end

  // Read above happens from the pre-edge contents, so D == MAX_LEN sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= in;
    end
  end

  assign out    = out_q;
  assign primed = primed_q;

endmodule
